// File: rtl/frame_capture_buffer_if.sv
// Sample-stream input and frame-presentation output bundle of frame_capture_buffer.
// The slave modport is the buffer's view; master is the producer/consumer side.
interface frame_capture_buffer_if #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]  in_sample;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  frame_out [0:DEPTH-1];
    logic              frame_valid;
    logic              frame_ack;
    logic [FILL_W-1:0] fill_level;
    logic [15:0]       frame_count;

    modport master (
        output in_sample, in_valid, frame_ack,
        input  in_ready, frame_out, frame_valid, fill_level, frame_count
    );

    modport slave (
        input  in_sample, in_valid, frame_ack,
        output in_ready, frame_out, frame_valid, fill_level, frame_count
    );
endinterface

// File: rtl/frame_capture_buffer.sv
// Double-buffered capture of a serial sample stream into DEPTH-sample frames.
// The capture bank fills serially; completed frames are copied whole into the hold bank.
module frame_capture_buffer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_capture_buffer_if.slave bus
);
    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(DEPTH - 1);

    typedef enum logic {
        S_FILL,
        S_STALL
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_capture [0:DEPTH-1];
    logic [WIDTH-1:0] r_hold    [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic             r_frame_valid;
    logic [15:0]      r_frame_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_complete;
    logic             w_xfer_fill;
    logic             w_xfer_stall;
    logic             w_release;

    // ---------------- FSM: state register ----------------
    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: each combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL: begin
                if (w_complete && r_frame_valid && !bus.frame_ack) begin
                    w_state_next = S_STALL;
                end
            end
            S_STALL: begin
                if (bus.frame_ack) begin
                    w_state_next = S_FILL;
                end
            end
            default: w_state_next = S_FILL;
        endcase
    end

    // ---------------- FSM: output / control decode ----------------
    always_comb begin
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_xfer_fill  = 1'b0;
        w_xfer_stall = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_FILL: begin
                w_in_ready  = !rst;
                w_accept    = bus.in_valid && w_in_ready;
                w_complete  = w_accept && (r_wr_ptr == LAST_IDX);
                // A completing sample with a simultaneous ack transfers instead of stalling.
                w_xfer_fill = w_complete && (!r_frame_valid || bus.frame_ack);
                w_release   = bus.frame_ack && r_frame_valid && !w_complete;
            end
            S_STALL: begin
                w_xfer_stall = bus.frame_ack;
            end
            default: ;
        endcase
    end

    // ---------------- Capture bank ----------------
    // NOTE: the capture memory is deliberately not reset; its contents are only
    // observable after being rewritten, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_capture[r_wr_ptr] <= bus.in_sample;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
    end

    // ---------------- Hold bank ----------------
    // In FILL the final sample bypasses the capture bank; in STALL it is already stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hold[i] <= '0;
            end
        end else if (w_xfer_fill || w_xfer_stall) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_hold[i] <= r_capture[i];
            end
            r_hold[DEPTH-1] <= w_xfer_fill ? bus.in_sample : r_capture[DEPTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_valid <= 1'b0;
            r_frame_count <= '0;
        end else if (w_xfer_fill || w_xfer_stall) begin
            r_frame_valid <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
        end else if (w_release) begin
            r_frame_valid <= 1'b0;
        end
    end

    // ---------------- Outputs ----------------
    assign bus.in_ready    = w_in_ready;
    assign bus.frame_out   = r_hold;
    assign bus.frame_valid = r_frame_valid;
    assign bus.fill_level  = {1'b0, r_wr_ptr};
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Directed bench for frame_capture_buffer: reset, single frame, backpressure,
// simultaneous ack/completion, gapped input and spurious ack.
module tb_frame_capture_buffer;
    localparam int DEPTH = 256;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    frame_capture_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    frame_capture_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int fv_before;
    int not_ready;
    int fv_low;
    int accepted;
    int fill_bad;
    int cycles;
    int v;
    int take;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] s, input logic ack);
        bus.in_sample = s;
        bus.in_valid  = 1'b1;
        bus.frame_ack = ack;
        step();
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.frame_ack = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.in_valid  = 1'b0;
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
    endtask

    // Expected frame contents: 0 zero, 1 ramp, 2 const 0x80, 3 descending, 4 gapped pattern.
    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'h00;
            1:       return 8'(i);
            2:       return 8'h80;
            3:       return 8'(255 - i);
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    task automatic check_frame(input string tag, input int kind);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.frame_out[i] !== pat(kind, i)) bad++;
        end
        check(tag, bad, 0);
    endtask

    // 51-tap moving average the downstream filter computes from frame_out.
    function automatic int mov_avg(input int n);
        int sum;
        sum = 0;
        for (int k = n - 50; k <= n; k++) sum += int'(bus.frame_out[k]);
        return sum / 51;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.in_sample = '0;
        bus.in_valid  = 1'b0;
        bus.frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("in_ready_during_reset", bus.in_ready, 0);
        rst = 1'b0;

        // Reset mid-frame after 100 accepted samples
        for (int i = 0; i < 100; i++) push(8'(i), 1'b0);
        idle();
        check("fill_mid_frame", bus.fill_level, 100);
        #2 rst = 1'b1;
        #1;
        check("rst_frame_valid", bus.frame_valid, 0);
        check("rst_fill_level", bus.fill_level, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check_frame("rst_frame_out_zero", 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", bus.in_ready, 1);
        @(negedge clk);

        // Single ramp frame
        fv_before = 0;
        for (int i = 0; i < 256; i++) begin
            push(8'(i), 1'b0);
            if (i == 254) fv_before = int'(bus.frame_valid);
        end
        idle();
        check("ramp_valid_before_last", fv_before, 0);
        check("ramp_frame_valid", bus.frame_valid, 1);
        check_frame("ramp_frame_out", 1);
        check("ramp_frame_count", bus.frame_count, 1);
        check("ramp_fill_level", bus.fill_level, 0);
        check("ramp_in_ready", bus.in_ready, 1);
        check("filter_avg_50", mov_avg(50), 25);
        check("filter_avg_255", mov_avg(255), 230);

        // Release, then spurious ack
        pulse_ack();
        check("release_frame_valid", bus.frame_valid, 0);
        check_frame("release_frame_kept", 1);
        check("release_frame_count", bus.frame_count, 1);
        pulse_ack();
        check("spurious_frame_valid", bus.frame_valid, 0);
        check("spurious_frame_count", bus.frame_count, 1);
        check("spurious_fill_level", bus.fill_level, 0);
        check("spurious_in_ready", bus.in_ready, 1);
        check_frame("spurious_frame_kept", 1);

        // Backpressure: 512 samples of 0x80 with no ack
        not_ready = 0;
        for (int i = 0; i < 512; i++) begin
            if (!bus.in_ready) not_ready++;
            push(8'h80, 1'b0);
        end
        idle();
        check("bp_ready_while_filling", not_ready, 0);
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_frame_valid", bus.frame_valid, 1);
        check("bp_frame_count", bus.frame_count, 2);
        check("bp_fill_level", bus.fill_level, 0);
        check_frame("bp_frame_out", 2);
        bus.in_sample = 8'h11;
        bus.in_valid  = 1'b1;
        step();
        step();
        check("stall_no_accept_ready", bus.in_ready, 0);
        check("stall_no_accept_fill", bus.fill_level, 0);
        pulse_ack();
        check("bp_ack_frame_valid", bus.frame_valid, 1);
        check("bp_ack_frame_count", bus.frame_count, 3);
        check("bp_ack_in_ready", bus.in_ready, 1);
        check("bp_ack_fill_level", bus.fill_level, 0);
        check_frame("bp_ack_frame_out", 2);

        // Completion and ack on the same edge
        fv_low = 0;
        not_ready = 0;
        for (int i = 0; i < 256; i++) begin
            if (!bus.in_ready) not_ready++;
            push(8'(255 - i), i == 255);
            if (!bus.frame_valid) fv_low++;
        end
        idle();
        check("simul_ready_throughout", not_ready, 0);
        check("simul_valid_never_low", fv_low, 0);
        check("simul_no_stall", bus.in_ready, 1);
        check("simul_frame_count", bus.frame_count, 4);
        check_frame("simul_frame_out", 3);

        // Gapped input at ~50% valid duty, ending in a stall
        accepted = 0;
        fill_bad = 0;
        cycles   = 0;
        while (accepted < 256 && cycles < 4000) begin
            v = int'($urandom_range(0, 1));
            bus.in_valid  = (v != 0);
            bus.in_sample = (v != 0) ? pat(4, accepted) : 8'hEE;
            take = ((v != 0) && bus.in_ready) ? 1 : 0;
            step();
            if (take != 0) accepted++;
            if (int'(bus.fill_level) != (accepted % 256)) fill_bad++;
            cycles++;
        end
        idle();
        check("gap_accepted_in_budget", accepted, 256);
        check("gap_fill_tracking", fill_bad, 0);
        check("gap_stall_in_ready", bus.in_ready, 0);
        check("gap_stall_count", bus.frame_count, 4);
        check_frame("gap_stall_hold_kept", 3);
        pulse_ack();
        check("gap_ack_frame_valid", bus.frame_valid, 1);
        check("gap_ack_frame_count", bus.frame_count, 5);
        check("gap_ack_in_ready", bus.in_ready, 1);
        check_frame("gap_frame_out", 4);
        push(8'h5A, 1'b0);
        idle();
        check("restart_fill_level", bus.fill_level, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
